// File: rtl/ysyx_23060208_axil_wr_master.sv
// AXI-Lite write initiator: takes one LSU store at a time, drives AW/W/B and
// returns the write response on a valid/ready completion port.
module ysyx_23060208_axil_wr_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    done_valid,
   input  logic                    done_ready,
   output logic [1:0]              done_resp,
   output logic [7:0]              err_cnt,
   output logic [ADDR_WIDTH-1:0]   m_awaddr,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   input  logic [1:0]              m_bresp,
   input  logic                    m_bvalid,
   output logic                    m_bready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_B, RESP} state_t;

   state_t                  state_q, state_d;
   logic                    req_ready_q, req_ready_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic [1:0]              done_resp_q, done_resp_d;
   logic [7:0]              err_cnt_q, err_cnt_d;
   logic                    aw_hs, w_hs;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         done_resp_q <= 2'b00;
         err_cnt_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         done_resp_q <= done_resp_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign aw_hs = awvalid_q & m_awready;
   assign w_hs  = wvalid_q & m_wready;

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      done_resp_d = done_resp_q;
      err_cnt_d   = err_cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               awaddr_d  = req_addr;
               wdata_d   = req_wdata;
               wstrb_d   = req_wstrb;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            // A handshake in this very cycle counts as complete.
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (m_bvalid) begin
               done_resp_d = m_bresp;
               if (m_bresp != 2'b00 && err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            if (done_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Registered so req_ready stays low while reset is held.
      req_ready_d = (state_d == IDLE);
   end

   assign req_ready  = req_ready_q;
   assign m_awvalid  = awvalid_q;
   assign m_wvalid   = wvalid_q;
   assign m_awaddr   = awaddr_q;
   assign m_wdata    = wdata_q;
   assign m_wstrb    = wstrb_q;
   assign m_bready   = (state_q == WAIT_B);
   assign done_valid = (state_q == RESP);
   assign done_resp  = done_resp_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ysyx_23060208_axil_wr_master.sv
// Directed bench for the AXI-Lite write initiator; the responder side is
// driven by hand, cycle by cycle.
module tb_ysyx_23060208_axil_wr_master;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        done_valid;
   logic        done_ready;
   logic [1:0]  done_resp;
   logic [7:0]  err_cnt;
   logic [31:0] m_awaddr;
   logic        m_awvalid;
   logic        m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid;
   logic        m_wready;
   logic [1:0]  m_bresp;
   logic        m_bvalid;
   logic        m_bready;

   int errors = 0;
   int checks = 0;
   int aw_hs_cnt = 0;
   int w_hs_cnt = 0;

   ysyx_23060208_axil_wr_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .done_valid(done_valid), .done_ready(done_ready),
      .done_resp(done_resp), .err_cnt(err_cnt),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (m_awvalid && m_awready) aw_hs_cnt <= aw_hs_cnt + 1;
      if (m_wvalid && m_wready)   w_hs_cnt  <= w_hs_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // All-ready store answered with resp; starts in a cycle where req_ready=1.
   task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
      req_valid = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = resp;
      done_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("rs_awaddr", m_awaddr, a);
      tick();
      tick();
      chk("rs_done_valid", {31'd0, done_valid}, 32'd1);
      chk("rs_done_resp", {30'd0, done_resp}, {30'd0, resp});
      tick();
      m_bvalid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      done_ready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      m_bresp = 2'b00; m_bvalid = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_valids", {29'd0, m_awvalid, m_wvalid, m_bready}, 32'd0);
      chk("rst_done", {21'd0, done_valid, done_resp, err_cnt}, 32'd0);
      chk("rst_awaddr", m_awaddr, 32'd0);
      chk("rst_wdata", m_wdata, 32'd0);
      chk("rst_wstrb", {28'd0, m_wstrb}, 32'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
      $display("reset: req_ready=%0b err_cnt=%0d", req_ready, err_cnt);

      // All-ready single store, cycle-exact
      req_valid = 1'b1; req_addr = 32'ha00003f8; req_wdata = 32'h00000041; req_wstrb = 4'b0001;
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00; done_ready = 1'b1;
      tick(); // cycle 1
      req_valid = 1'b0;
      chk("c1_valids", {30'd0, m_awvalid, m_wvalid}, 32'd3);
      chk("c1_awaddr", m_awaddr, 32'ha00003f8);
      chk("c1_wdata", m_wdata, 32'h00000041);
      chk("c1_wstrb", {28'd0, m_wstrb}, 32'h1);
      chk("c1_bready", {30'd0, m_bready, req_ready}, 32'd0);
      tick(); // cycle 2
      chk("c2_bready", {31'd0, m_bready}, 32'd1);
      chk("c2_valids", {29'd0, m_awvalid, m_wvalid, done_valid}, 32'd0);
      tick(); // cycle 3
      chk("c3_done_valid", {31'd0, done_valid}, 32'd1);
      chk("c3_resp_cnt", {22'd0, done_resp, err_cnt}, 32'd0);
      chk("c3_bready", {30'd0, m_bready, req_ready}, 32'd0);
      tick(); // cycle 4
      m_bvalid = 1'b0;
      chk("c4_req_ready", {30'd0, req_ready, done_valid}, 32'd2);
      $display("single store: done_resp=%0d err_cnt=%0d", done_resp, err_cnt);

      // AW before W: wready low for cycles 1..5
      aw_hs_cnt = 0; w_hs_cnt = 0;
      req_valid = 1'b1; req_addr = 32'h00001000; req_wdata = 32'hdeadbeef; req_wstrb = 4'hf;
      m_awready = 1'b1; m_wready = 1'b0;
      tick();
      req_valid = 1'b0; req_wdata = 32'h0;
      chk("awfirst_c1", {30'd0, m_awvalid, m_wvalid}, 32'd3);
      for (int i = 2; i <= 5; i++) begin
         tick();
         chk("awfirst_stall_valids", {29'd0, m_awvalid, m_wvalid, m_bready}, 32'd2);
         chk("awfirst_stall_wdata", m_wdata, 32'hdeadbeef);
      end
      tick(); // cycle 6
      m_wready = 1'b1;
      chk("awfirst_c6", {29'd0, m_awvalid, m_wvalid, m_bready}, 32'd2);
      tick(); // cycle 7
      m_wready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00;
      chk("awfirst_bready", {29'd0, m_awvalid, m_wvalid, m_bready}, 32'd1);
      chk("awfirst_hs", aw_hs_cnt * 16 + w_hs_cnt, 32'h11);
      tick();
      m_bvalid = 1'b0;
      chk("awfirst_done", {29'd0, done_valid, done_resp}, 32'd4);
      tick();
      $display("aw-before-w: aw_hs=%0d w_hs=%0d", aw_hs_cnt, w_hs_cnt);

      // W before AW: awready low for cycles 1..3
      aw_hs_cnt = 0; w_hs_cnt = 0;
      req_valid = 1'b1; req_addr = 32'h80000010; req_wdata = 32'h12345678; req_wstrb = 4'b1100;
      m_awready = 1'b0; m_wready = 1'b1;
      tick();
      req_valid = 1'b0; req_addr = 32'h0;
      for (int i = 2; i <= 3; i++) begin
         tick();
         chk("wfirst_stall_valids", {29'd0, m_awvalid, m_wvalid, m_bready}, 32'd4);
         chk("wfirst_stall_awaddr", m_awaddr, 32'h80000010);
      end
      tick(); // cycle 4
      m_awready = 1'b1;
      chk("wfirst_c4", {29'd0, m_awvalid, m_wvalid, m_bready}, 32'd4);
      tick(); // cycle 5
      m_bvalid = 1'b1; m_bresp = 2'b00;
      chk("wfirst_bready", {29'd0, m_awvalid, m_wvalid, m_bready}, 32'd1);
      chk("wfirst_hs", aw_hs_cnt * 16 + w_hs_cnt, 32'h11);
      tick();
      m_bvalid = 1'b0;
      chk("wfirst_done", {31'd0, done_valid}, 32'd1);
      tick();
      $display("w-before-aw: aw_hs=%0d w_hs=%0d", aw_hs_cnt, w_hs_cnt);

      // Error responses
      run_store(32'h10, 32'h1, 4'h1, 2'b10);
      chk("err_cnt_1", {24'd0, err_cnt}, 32'd1);
      run_store(32'h14, 32'h2, 4'h2, 2'b11);
      chk("err_cnt_2", {24'd0, err_cnt}, 32'd2);
      run_store(32'h18, 32'h3, 4'h4, 2'b00);
      chk("err_cnt_3", {24'd0, err_cnt}, 32'd2);
      $display("error responses: err_cnt=%0d", err_cnt);

      // Saturation: 252 more reach 0xFE, next reaches 0xFF, rest hold
      for (int i = 0; i < 252; i++) run_store(32'h100 + i, i, 4'hf, 2'b10);
      chk("err_cnt_fe", {24'd0, err_cnt}, 32'hfe);
      run_store(32'h200, 32'h0, 4'hf, 2'b10);
      chk("err_cnt_ff", {24'd0, err_cnt}, 32'hff);
      for (int i = 0; i < 47; i++) run_store(32'h300 + i, i, 4'hf, 2'b10);
      chk("err_cnt_sat", {24'd0, err_cnt}, 32'hff);
      $display("saturation: err_cnt=%0h", err_cnt);

      // Completion backpressure with req_valid held high
      req_valid = 1'b1; req_addr = 32'h40; req_wdata = 32'haa; req_wstrb = 4'hf;
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b01; done_ready = 1'b0;
      tick(); // cycle 1
      req_addr = 32'h44; req_wdata = 32'hbb;
      tick(); // cycle 2
      tick(); // cycle 3
      m_bresp = 2'b00;
      for (int i = 3; i <= 6; i++) begin
         chk("bp_hold", {29'd0, done_valid, done_resp}, 32'd5);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
         tick();
      end
      done_ready = 1'b1; // cycle 7
      chk("bp_c7", {28'd0, done_valid, done_resp, req_ready}, 32'd10);
      tick(); // cycle 8: next request accepted here
      chk("bp_c8_req_ready", {31'd0, req_ready}, 32'd1);
      tick(); // cycle 9
      req_valid = 1'b0;
      chk("bp_c9_awaddr", m_awaddr, 32'h44);
      chk("bp_c9_valids", {30'd0, m_awvalid, m_wvalid}, 32'd3);
      tick(); tick(); // cycle 11
      chk("bp_second_done", {29'd0, done_valid, done_resp}, 32'd4);
      tick();
      m_bvalid = 1'b0;
      $display("backpressure: second awaddr=%h", m_awaddr);

      // Reset mid-operation while AW is stalled
      req_valid = 1'b1; req_addr = 32'h50; req_wdata = 32'hcc; req_wstrb = 4'h3;
      m_awready = 1'b0; m_wready = 1'b1;
      tick(); // cycle 1
      req_valid = 1'b0;
      tick(); // cycle 2
      chk("mid_send_awvalid", {31'd0, m_awvalid}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valids", {27'd0, m_awvalid, m_wvalid, m_bready, done_valid, req_ready}, 32'd0);
      chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      tick();
      chk("mid_rst_idle", {30'd0, req_ready, done_valid}, 32'd2);
      run_store(32'h60, 32'hdd, 4'hf, 2'b00);
      chk("mid_rst_fresh_cnt", {24'd0, err_cnt}, 32'd0);
      chk("mid_rst_fresh_ready", {31'd0, req_ready}, 32'd1);
      $display("reset mid-op: err_cnt=%0d awaddr=%h", err_cnt, m_awaddr);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
